mmio_io_responder: RTL and testbench

- Memory-mapped I/O responder on the core's IO port; answers the loads and stores the memory stage steers to the 0x8000_00xx window.
- Owns the UART control/status, RX data and TX data registers, plus the cycle and instruction counters and the counter-reset strobe.
- Sits beside DMEM; its read data is registered so it joins the writeback mux with the same 1-cycle latency as synchronous BRAM.

---
 rtl/mmio_io_responder_pkg.sv | 20 ++
 rtl/io_rx_fifo.sv | 56 +++++
 rtl/mmio_io_responder.sv | 152 +++++++++++++++
 tb/tb_mmio_io_responder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_io_responder_pkg.sv
// Shared IO window map: register offsets and status bit positions used by the
// IO responder and by the memory-stage address decoder.
package mmio_io_responder_pkg;

   localparam logic [7:0] IO_UART_CTRL = 8'h00;
   localparam logic [7:0] IO_UART_RX   = 8'h04;
   localparam logic [7:0] IO_UART_TX   = 8'h08;
   localparam logic [7:0] IO_CYCLE_CNT = 8'h10;
   localparam logic [7:0] IO_INST_CNT  = 8'h14;
   localparam logic [7:0] IO_CNT_RST   = 8'h18;

   localparam int IO_STAT_TX_FREE  = 0;
   localparam int IO_STAT_RX_AVAIL = 1;

   // Registers are word-aligned, so the byte-lane bits never take part in decode.
   function automatic logic [7:0] ioWordOffset(input logic [7:0] byteOffset);
      return {byteOffset[7:2], 2'b00};
   endfunction

endpackage

// File: rtl/io_rx_fifo.sv
// Small power-of-two FIFO buffering received UART bytes until software reads
// them; a push into a full FIFO is accepted only when a pop frees a slot.
module io_rx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wrPtr_q, wrPtr_d;
   logic [AW-1:0]    rdPtr_q, rdPtr_d;
   logic [AW:0]      count_q, count_d;
   logic             doPush, doPop;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign doPop   = pop_i && !empty_o;
   assign doPush  = push_i && (!full_o || doPop);
   assign data_o  = mem_q[rdPtr_q];

   always_comb begin
      wrPtr_d = wrPtr_q + AW'(doPush);
      rdPtr_d = rdPtr_q + AW'(doPop);
      count_d = count_q + (AW+1)'(doPush) - (AW+1)'(doPop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (doPush) begin
         mem_q[wrPtr_q] <= data_i;
      end
   end

endmodule

// File: rtl/mmio_io_responder.sv
// IO-window responder: UART status/RX/TX registers plus cycle and instruction
// counters. Define IO_RX_FIFO_EN to buffer RX bytes in an io_rx_fifo.
module mmio_io_responder
   import mmio_io_responder_pkg::*;
#(
   parameter logic [31:0] ADDR_BASE     = 32'h8000_0000,
   parameter int          RX_FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] io_addr,
   input  logic        io_ren,
   input  logic        io_wen,
   input  logic [31:0] io_din,
   output logic [31:0] io_dout,
   input  logic        inst_retired,
   output logic [7:0]  uart_tx_data,
   output logic        uart_tx_valid,
   input  logic        uart_tx_ready,
   input  logic [7:0]  uart_rx_data,
   input  logic        uart_rx_valid,
   output logic        uart_rx_ready
);

   logic        hit, rdHit, wrHit;
   logic [7:0]  off;
   logic        unusedBits;

   logic        txFull_q, txFull_d;
   logic [7:0]  txData_q, txData_d;
   logic        txHandshake, txAccept;

   logic        rxAvail, rxRead, rxPop;
   logic [7:0]  rxByte;

   logic [31:0] cycleCnt_q, cycleCnt_d;
   logic [31:0] instCnt_q, instCnt_d;
   logic        cntClear;

   logic [31:0] readData;
   logic [31:0] ioDout_q, ioDout_d;

   assign hit        = (io_addr[31:8] == ADDR_BASE[31:8]);
   assign off        = ioWordOffset(io_addr[7:0]);
   assign rdHit      = io_ren && hit;
   assign wrHit      = io_wen && hit;
   assign unusedBits = ^{io_addr[1:0], io_din[31:8]};

   // A handshake frees the holding slot in the same cycle a new byte lands.
   assign txHandshake = txFull_q && uart_tx_ready;
   assign txAccept    = wrHit && (off == IO_UART_TX) && (!txFull_q || txHandshake);

   always_comb begin
      txFull_d = txFull_q;
      txData_d = txData_q;
      if (txAccept) begin
         txFull_d = 1'b1;
         txData_d = io_din[7:0];
      end else if (txHandshake) begin
         txFull_d = 1'b0;
      end
   end

   assign uart_tx_valid = txFull_q;
   assign uart_tx_data  = txData_q;
   assign rxRead        = rdHit && (off == IO_UART_RX);

`ifdef IO_RX_FIFO_EN
   logic fifoFull, fifoEmpty, fifoPush;

   assign uart_rx_ready = !rst && !fifoFull;
   assign fifoPush      = uart_rx_valid && uart_rx_ready;
   assign rxPop         = rxRead && !fifoEmpty;
   assign rxAvail       = !fifoEmpty;

   io_rx_fifo #(
      .DEPTH(RX_FIFO_DEPTH),
      .WIDTH(8)
   ) uRxFifo (
      .clk    (clk),
      .rst    (rst),
      .push_i (fifoPush),
      .data_i (uart_rx_data),
      .pop_i  (rxPop),
      .data_o (rxByte),
      .full_o (fifoFull),
      .empty_o(fifoEmpty)
   );
`else
   localparam int unusedFifoDepth = RX_FIFO_DEPTH;

   // Pass-through: the receiver's byte is consumed by the very read that returns it.
   assign rxAvail       = uart_rx_valid;
   assign rxByte        = uart_rx_data;
   assign rxPop         = rxRead && uart_rx_valid;
   assign uart_rx_ready = !rst && rxPop;
`endif

   assign cntClear = wrHit && (off == IO_CNT_RST);

   always_comb begin
      cycleCnt_d = cycleCnt_q + 32'd1;
      instCnt_d  = instCnt_q + {31'd0, inst_retired};
      if (cntClear) begin
         cycleCnt_d = '0;
         instCnt_d  = '0;
      end
   end

   // Reads see pre-update state, so a same-cycle clear still returns the old count.
   always_comb begin
      readData = '0;
      if (hit) begin
         case (off)
            IO_UART_CTRL: begin
               readData[IO_STAT_TX_FREE]  = !txFull_q;
               readData[IO_STAT_RX_AVAIL] = rxAvail;
            end
            IO_UART_RX:   readData = rxAvail ? {24'd0, rxByte} : 32'd0;
            IO_CYCLE_CNT: readData = cycleCnt_q;
            IO_INST_CNT:  readData = instCnt_q;
            default:      readData = '0;
         endcase
      end
   end

   always_comb begin
      ioDout_d = ioDout_q;
      if (io_ren) begin
         ioDout_d = readData;
      end
   end

   assign io_dout = ioDout_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         txFull_q   <= 1'b0;
         txData_q   <= '0;
         cycleCnt_q <= '0;
         instCnt_q  <= '0;
         ioDout_q   <= '0;
      end else begin
         txFull_q   <= txFull_d;
         txData_q   <= txData_d;
         cycleCnt_q <= cycleCnt_d;
         instCnt_q  <= instCnt_d;
         ioDout_q   <= ioDout_d;
      end
   end

endmodule

// File: tb/tb_mmio_io_responder.sv
// Self-checking bench for mmio_io_responder: directed scenarios followed by
// random register traffic, all checked against a queue-based reference model.
module tb_mmio_io_responder;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] io_addr;
   logic        io_ren, io_wen;
   logic [31:0] io_din;
   logic [31:0] io_dout;
   logic        inst_retired;
   logic [7:0]  uart_tx_data;
   logic        uart_tx_valid, uart_tx_ready;
   logic [7:0]  uart_rx_data;
   logic        uart_rx_valid, uart_rx_ready;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state
   bit         mTxFull;
   bit [7:0]   mTxData;
   bit [31:0]  mCyc, mInst, mDout;
   bit [7:0]   mRxQ[$];

   always #5 clk = ~clk;

   mmio_io_responder #(
      .ADDR_BASE    (32'h8000_0000),
      .RX_FIFO_DEPTH(DEPTH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .io_addr      (io_addr),
      .io_ren       (io_ren),
      .io_wen       (io_wen),
      .io_din       (io_din),
      .io_dout      (io_dout),
      .inst_retired (inst_retired),
      .uart_tx_data (uart_tx_data),
      .uart_tx_valid(uart_tx_valid),
      .uart_tx_ready(uart_tx_ready),
      .uart_rx_data (uart_rx_data),
      .uart_rx_valid(uart_rx_valid),
      .uart_rx_ready(uart_rx_ready)
   );

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic void modelReset();
      mTxFull = 1'b0;
      mTxData = 8'h00;
      mCyc    = 32'd0;
      mInst   = 32'd0;
      mDout   = 32'd0;
      mRxQ.delete();
   endfunction

   // Called at a falling edge; drives one cycle, advances the model, returns at the next falling edge.
   task automatic applyStimulus(input bit ren, input bit wen, input logic [31:0] addr,
                                input logic [31:0] din, input bit retire, input bit txReady,
                                input bit rxValid, input logic [7:0] rxData);
      bit        hit, rxAvail, expReady, handshake, rxRd, doPush, doPop;
      bit [7:0]  off, headByte;
      bit [31:0] readVal;
      io_addr       = addr;
      io_ren        = ren;
      io_wen        = wen;
      io_din        = din;
      inst_retired  = retire;
      uart_tx_ready = txReady;
      uart_rx_valid = rxValid;
      uart_rx_data  = rxData;
      #1;
      hit      = (addr[31:8] == 24'h80_0000);
      off      = {addr[7:2], 2'b00};
      rxRd     = ren && hit && (off == 8'h04);
      headByte = 8'h00;
`ifdef IO_RX_FIFO_EN
      rxAvail  = (mRxQ.size() != 0);
      expReady = (mRxQ.size() < DEPTH);
      if (rxAvail) headByte = mRxQ[0];
`else
      rxAvail  = rxValid;
      expReady = rxRd && rxValid;
      headByte = rxData;
`endif
      checkOutput("tx_valid", {31'd0, uart_tx_valid}, {31'd0, mTxFull});
      checkOutput("tx_data", {24'd0, uart_tx_data}, {24'd0, mTxData});
      checkOutput("rx_ready", {31'd0, uart_rx_ready}, {31'd0, expReady});

      readVal = 32'd0;
      if (hit) begin
         if (off == 8'h00) readVal = {30'd0, rxAvail, !mTxFull};
         else if (off == 8'h04) readVal = rxAvail ? {24'd0, headByte} : 32'd0;
         else if (off == 8'h10) readVal = mCyc;
         else if (off == 8'h14) readVal = mInst;
      end
      if (ren) mDout = readVal;

      handshake = mTxFull && txReady;
      if (wen && hit && off == 8'h08 && (!mTxFull || handshake)) begin
         mTxFull = 1'b1;
         mTxData = din[7:0];
      end else if (handshake) begin
         mTxFull = 1'b0;
      end

      doPush = rxValid && expReady;
      doPop  = rxRd && rxAvail;
`ifdef IO_RX_FIFO_EN
      if (doPop) void'(mRxQ.pop_front());
      if (doPush) mRxQ.push_back(rxData);
`else
      if (doPush && doPop) mRxQ.delete();
`endif

      if (wen && hit && off == 8'h18) begin
         mCyc  = 32'd0;
         mInst = 32'd0;
      end else begin
         mCyc  = mCyc + 32'd1;
         mInst = mInst + {31'd0, retire};
      end

      @(posedge clk);
      @(negedge clk);
      checkOutput("io_dout", io_dout, mDout);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 0, 8'h00);
   endtask

   task automatic readReg(input logic [31:0] addr);
      applyStimulus(1, 0, addr, 32'h0, 0, 0, 0, 8'h00);
   endtask

   task automatic doReset();
      rst           = 1'b1;
      io_addr       = '0;
      io_ren        = 1'b0;
      io_wen        = 1'b0;
      io_din        = '0;
      inst_retired  = 1'b0;
      uart_tx_ready = 1'b0;
      uart_rx_valid = 1'b1;
      uart_rx_data  = 8'hA5;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rx_ready_in_reset", {31'd0, uart_rx_ready}, 32'd0);
      uart_rx_valid = 1'b0;
      rst           = 1'b0;
      modelReset();
      checkOutput("dout_reset", io_dout, 32'd0);
      checkOutput("tx_valid_reset", {31'd0, uart_tx_valid}, 32'd0);
   endtask

   function automatic logic [31:0] randAddr();
      logic [7:0] offs [9];
      logic [31:0] base;
      offs = '{8'h00, 8'h04, 8'h08, 8'h10, 8'h14, 8'h18, 8'h0C, 8'h1C, 8'h40};
      base = ($urandom_range(0, 15) == 0) ? 32'h9000_0000 : 32'h8000_0000;
      return base | {24'd0, offs[$urandom_range(0, 8)]} | 32'($urandom_range(0, 3));
   endfunction

   initial begin
      doReset();

      // Counter starts at 0 in the first cycle after release
      idle(5);
      readReg(32'h8000_0010);
      checkOutput("cycle_at_5", io_dout, 32'd5);
      readReg(32'h8000_0000);
      checkOutput("status_idle", io_dout, 32'h1);

      // TX: one byte held while ready is low, a second write while full is dropped
      applyStimulus(0, 1, 32'h8000_0008, 32'h41, 0, 0, 0, 8'h00);
      readReg(32'h8000_0000);
      checkOutput("status_tx_busy", io_dout, 32'h0);
      applyStimulus(0, 1, 32'h8000_0008, 32'h42, 0, 0, 0, 8'h00);
      checkOutput("tx_drop_data", {24'd0, uart_tx_data}, 32'h41);
      applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 0, 8'h00);
      applyStimulus(0, 0, 32'h0, 32'h0, 0, 1, 0, 8'h00);
      checkOutput("tx_done", {31'd0, uart_tx_valid}, 32'd0);
      readReg(32'h8000_0000);
      checkOutput("status_tx_free", io_dout, 32'h1);

      // Back-to-back: new write in the handshake cycle
      applyStimulus(0, 1, 32'h8000_0008, 32'h61, 0, 0, 0, 8'h00);
      applyStimulus(0, 1, 32'h8000_0008, 32'h62, 0, 1, 0, 8'h00);
      checkOutput("tx_b2b", {23'd0, uart_tx_valid, uart_tx_data}, 32'h162);
      applyStimulus(0, 0, 32'h0, 32'h0, 0, 1, 0, 8'h00);

`ifndef IO_RX_FIFO_EN
      applyStimulus(1, 0, 32'h8000_0004, 32'h0, 0, 0, 1, 8'h5A);
      checkOutput("rx_read", io_dout, 32'h5A);
      readReg(32'h8000_0004);
      checkOutput("rx_read_empty", io_dout, 32'h0);
`else
      for (int i = 0; i < 5; i++) applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 1, 8'(8'h10 + i));
      checkOutput("fifo_full_ready", {31'd0, uart_rx_ready}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         readReg(32'h8000_0004);
         checkOutput("fifo_order", io_dout, 32'(8'h10 + i));
      end
      readReg(32'h8000_0000);
      checkOutput("fifo_drained", io_dout, 32'h1);
`endif

      // Counters: clear wins over a same-cycle retire
      for (int i = 0; i < 10; i++) applyStimulus(0, 0, 32'h0, 32'h0, 1, 0, 0, 8'h00);
      readReg(32'h8000_0014);
      checkOutput("inst_10", io_dout, 32'd10);
      applyStimulus(0, 1, 32'h8000_0018, 32'hDEAD, 1, 0, 0, 8'h00);
      readReg(32'h8000_0014);
      checkOutput("inst_cleared", io_dout, 32'd0);
      readReg(32'h8000_0010);
      checkOutput("cycle_cleared", io_dout, 32'd1);

      force dut.instCnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.instCnt_q;
      mInst = 32'hFFFF_FFFF;
      applyStimulus(0, 0, 32'h0, 32'h0, 1, 0, 0, 8'h00);
      readReg(32'h8000_0014);
      checkOutput("inst_wrap", io_dout, 32'd0);

      // Reset mid-transfer aborts the pending byte
      applyStimulus(0, 1, 32'h8000_0008, 32'h77, 0, 0, 0, 8'h00);
      doReset();
      idle(1);

      for (int i = 0; i < 600; i++) begin
         applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, randAddr(),
                       $urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
                       $urandom_range(0, 1) == 1, 8'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
